// File: rtl/uart_tx_engine.sv
// UART transmitter: control FSM, baud timer, bit counter and shift register.
// Frame: start bit, DATA_BITS data bits LSB first, optional parity bit,
// STOP_BITS stop bits. tx is registered and idles high.
// Optional feature: define UART_TX_PARITY_EN to insert a parity bit after
// the data bits (even parity, or odd when PARITY_ODD=1).
module uart_tx_engine #(
  parameter int unsigned DATA_BITS    = 8,
  parameter int unsigned CLKS_PER_BIT = 868,
  parameter int unsigned STOP_BITS    = 1,
  parameter int unsigned PARITY_ODD   = 0
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic [DATA_BITS-1:0] data,
  input  logic                 send,
  input  logic                 hold,
  output logic                 busy,
  output logic                 done,
  output logic                 tx
);

  localparam int unsigned TimerW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam int unsigned BitW   = $clog2(DATA_BITS + 1);

  localparam logic [TimerW-1:0] TimerLast = TimerW'(CLKS_PER_BIT - 1);
  localparam logic [BitW-1:0]   DataLast  = BitW'(DATA_BITS - 1);
  // The bit counter is reused to count stop bits.
  localparam logic [BitW-1:0]   StopLast  = BitW'(STOP_BITS - 1);

`ifdef UART_TX_PARITY_EN
  typedef enum logic [2:0] {
    StIdle   = 3'd0,
    StStart  = 3'd1,
    StData   = 3'd2,
    StParity = 3'd3,
    StStop   = 3'd4
  } state_e;
`else
  typedef enum logic [2:0] {
    StIdle  = 3'd0,
    StStart = 3'd1,
    StData  = 3'd2,
    StStop  = 3'd4
  } state_e;
`endif

  state_e                state_q, state_d;
  logic [TimerW-1:0]     timer_q, timer_d;
  logic [BitW-1:0]       bit_q, bit_d;
  logic [DATA_BITS-1:0]  shift_q, shift_d;
  logic                  tx_q, tx_d;
  logic                  done_q, done_d;
  logic                  bit_end;

`ifdef UART_TX_PARITY_EN
  logic                  parity_q, parity_d;
`endif

  assign bit_end = (timer_q == TimerLast);
  assign busy    = (state_q != StIdle);
  assign done    = done_q;
  assign tx      = tx_q;

  // State and datapath registers, synchronous active-high reset.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q  <= StIdle;
      timer_q  <= '0;
      bit_q    <= '0;
      shift_q  <= '0;
      tx_q     <= 1'b1;
      done_q   <= 1'b0;
`ifdef UART_TX_PARITY_EN
      parity_q <= 1'b0;
`endif
    end else begin
      state_q  <= state_d;
      timer_q  <= timer_d;
      bit_q    <= bit_d;
      shift_q  <= shift_d;
      tx_q     <= tx_d;
      done_q   <= done_d;
`ifdef UART_TX_PARITY_EN
      parity_q <= parity_d;
`endif
    end
  end

  // Next-state logic; tx_d is the line level for the state being entered.
  always_comb begin
    state_d  = state_q;
    timer_d  = bit_end ? '0 : timer_q + 1'b1;
    bit_d    = bit_q;
    shift_d  = shift_q;
    tx_d     = tx_q;
    done_d   = 1'b0;
`ifdef UART_TX_PARITY_EN
    parity_d = parity_q;
`endif

    unique case (state_q)
      StIdle: begin
        timer_d = '0;
        tx_d    = 1'b1;
        if (send && !hold) begin
          state_d  = StStart;
          shift_d  = data;
          bit_d    = '0;
          tx_d     = 1'b0;
`ifdef UART_TX_PARITY_EN
          parity_d = (^data) ^ PARITY_ODD[0];
`endif
        end
      end

      StStart: begin
        if (bit_end) begin
          state_d = StData;
          tx_d    = shift_q[0];
        end
      end

      StData: begin
        if (bit_end) begin
          shift_d = shift_q >> 1;
          if (bit_q == DataLast) begin
            bit_d = '0;
`ifdef UART_TX_PARITY_EN
            state_d = StParity;
            tx_d    = parity_q;
`else
            state_d = StStop;
            tx_d    = 1'b1;
`endif
          end else begin
            bit_d = bit_q + 1'b1;
            tx_d  = shift_q[1];
          end
        end
      end

`ifdef UART_TX_PARITY_EN
      StParity: begin
        if (bit_end) begin
          state_d = StStop;
          bit_d   = '0;
          tx_d    = 1'b1;
        end
      end
`endif

      StStop: begin
        tx_d = 1'b1;
        if (bit_end) begin
          if (bit_q == StopLast) begin
            state_d = StIdle;
            bit_d   = '0;
            done_d  = 1'b1;
          end else begin
            bit_d = bit_q + 1'b1;
          end
        end
      end

      default: begin
        state_d = StIdle;
        timer_d = '0;
        bit_d   = '0;
        tx_d    = 1'b1;
      end
    endcase
  end

endmodule

// File: tb/tb_uart_tx_engine.sv
// Self-checking bench for uart_tx_engine. Two instances with different
// parameters share one stimulus stream; each has a reference model that
// expands every accepted frame into a queue of per-cycle tx levels.
module tb_uart_tx_engine;

  localparam int DB0 = 8, CPB0 = 4, SB0 = 1, PO0 = 0;
  localparam int DB1 = 5, CPB1 = 3, SB1 = 2, PO1 = 1;

  logic       clock = 1'b0;
  logic       reset = 1'b1;
  logic       send  = 1'b0;
  logic       hold  = 1'b0;
  logic [8:0] data  = '0;
  logic       busy0, done0, tx0;
  logic       busy1, done1, tx1;

  int n_vec = 0;
  int n_err = 0;
  int cyc   = 0;

  // Model state: remaining per-cycle tx levels of the frame in flight.
  bit q0[$];
  bit q1[$];
  bit done_m0 = 1'b0;
  bit done_m1 = 1'b0;

  always #5 clock = ~clock;

  uart_tx_engine #(
    .DATA_BITS(DB0), .CLKS_PER_BIT(CPB0), .STOP_BITS(SB0), .PARITY_ODD(PO0)
  ) dut0 (
    .clock(clock), .reset(reset), .data(data[DB0-1:0]), .send(send), .hold(hold),
    .busy(busy0), .done(done0), .tx(tx0)
  );

  uart_tx_engine #(
    .DATA_BITS(DB1), .CLKS_PER_BIT(CPB1), .STOP_BITS(SB1), .PARITY_ODD(PO1)
  ) dut1 (
    .clock(clock), .reset(reset), .data(data[DB1-1:0]), .send(send), .hold(hold),
    .busy(busy1), .done(done1), .tx(tx1)
  );

  // Bit sequence of one frame, index 0 goes on the line first.
  function automatic void build(input int db, input int sb, input int po,
                                input logic [8:0] d, output bit [12:0] bits,
                                output int len);
    bits = '0;
    len  = 0;
    bits[len] = 1'b0;
    len++;
    for (int i = 0; i < db; i++) begin
      bits[len] = d[i];
      len++;
    end
`ifdef UART_TX_PARITY_EN
    begin
      bit p;
      p = (po != 0);
      for (int i = 0; i < db; i++) p ^= d[i];
      bits[len] = p;
      len++;
    end
`else
    if (po > 1) len = len + 0;
`endif
    for (int i = 0; i < sb; i++) begin
      bits[len] = 1'b1;
      len++;
    end
  endfunction

  task automatic model_edge(input logic s, input logic h, input logic r,
                            input logic [8:0] d);
    bit [12:0] fb;
    int        len;
    if (r) begin
      q0.delete();
      done_m0 = 1'b0;
    end else if (q0.size() == 0) begin
      done_m0 = 1'b0;
      if (s && !h) begin
        build(DB0, SB0, PO0, d, fb, len);
        for (int i = 0; i < len; i++)
          for (int k = 0; k < CPB0; k++) q0.push_back(fb[i]);
      end
    end else begin
      void'(q0.pop_front());
      done_m0 = (q0.size() == 0);
    end

    if (r) begin
      q1.delete();
      done_m1 = 1'b0;
    end else if (q1.size() == 0) begin
      done_m1 = 1'b0;
      if (s && !h) begin
        build(DB1, SB1, PO1, d, fb, len);
        for (int i = 0; i < len; i++)
          for (int k = 0; k < CPB1; k++) q1.push_back(fb[i]);
      end
    end else begin
      void'(q1.pop_front());
      done_m1 = (q1.size() == 0);
    end
  endtask

  task automatic chk(input string tag, input logic got, input logic exp);
    n_vec++;
    assert (got === exp) else begin
      n_err++;
      $error("FAIL %s cycle %0d: observed %b expected %b", tag, cyc, got, exp);
    end
  endtask

  // Apply inputs for one clock, advance the model, then check after the edge.
  task automatic step(input logic s, input logic h, input logic r, input logic [8:0] d);
    send  = s;
    hold  = h;
    reset = r;
    data  = d;
    @(posedge clock);
    cyc++;
    model_edge(s, h, r, d);
    #1;
    chk("tx0",   tx0,   (q0.size() != 0) ? q0[0] : 1'b1);
    chk("busy0", busy0, q0.size() != 0);
    chk("done0", done0, done_m0);
    chk("tx1",   tx1,   (q1.size() != 0) ? q1[0] : 1'b1);
    chk("busy1", busy1, q1.size() != 0);
    chk("done1", done1, done_m1);
  endtask

  initial begin
    logic       s, h, r;
    logic [8:0] d;

    // Reset state.
    step(1'b0, 1'b0, 1'b1, 9'h000);
    step(1'b0, 1'b0, 1'b1, 9'h000);

    // Single frame of 0xA5 and its completion pulse.
    step(1'b1, 1'b0, 1'b0, 9'h0A5);
    repeat (50) step(1'b0, 1'b0, 1'b0, 9'h000);

    // Flow control: hold blocks the start, release starts on the next edge.
    repeat (10) step(1'b1, 1'b1, 1'b0, 9'h05A);
    step(1'b1, 1'b0, 1'b0, 9'h05A);
    // hold toggling mid-frame must not matter.
    repeat (8) step(1'b0, 1'b1, 1'b0, 9'h000);

    // Back-to-back: request again in the done cycle of the current frame.
    for (int i = 0; i < 100 && !done_m0; i++) step(1'b0, 1'b0, 1'b0, 9'h000);
    step(1'b1, 1'b0, 1'b0, 9'h03C);

    // A request while busy is ignored.
    repeat (10) step(1'b0, 1'b0, 1'b0, 9'h000);
    repeat (4) step(1'b1, 1'b0, 1'b0, 9'h0FF);
    for (int i = 0; i < 100 && q0.size() != 0; i++) step(1'b0, 1'b0, 1'b0, 9'h000);
    repeat (20) step(1'b0, 1'b0, 1'b0, 9'h000);

    // Reset mid-frame aborts without a completion pulse.
    step(1'b1, 1'b0, 1'b0, 9'h0A5);
    repeat (14) step(1'b0, 1'b0, 1'b0, 9'h000);
    step(1'b0, 1'b0, 1'b1, 9'h000);
    repeat (50) step(1'b0, 1'b0, 1'b0, 9'h000);

    // Randomised traffic with occasional hold and reset.
    repeat (1500) begin
      s = ($urandom_range(0, 3) == 0);
      h = ($urandom_range(0, 4) == 0);
      r = ($urandom_range(0, 299) == 0);
      d = 9'($urandom);
      step(s, h, r, d);
    end
    repeat (60) step(1'b0, 1'b0, 1'b0, 9'h000);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
